grf_wb_queue: RTL

- Write-back queue on the producer side of the GRF write port (WE/wt/wdata/wPc).
- Accepts register-write requests from result producers (ALU, DM load path, later MDU) via valid/ready, buffers them in order, and drains one write per cycle into the GRF.
- Decouples bursty producers from the single GRF write port; instantiated between the W-stage mux and grf.

---
 rtl/grf_pkg.sv | 16 +
 rtl/wb_match.sv | 35 +++
 rtl/grf_wb_queue.sv | 119 +++++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// Shared GRF definitions: register-address/data widths, the zero register and
// the write-back entry payload used by the write-back queue.
package grf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One pending GRF write: destination, value and producing PC.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] wt;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     pc;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Bypass lookup over the write-back queue: reports whether any valid entry
// targets addr and returns the youngest matching entry's data.
// Ports: entries/valid (queue storage and valid mask), head (oldest slot),
//        addr (query register), hit_c/data_c (combinational result).
module wb_match
  import grf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       head,
  input  logic [REG_ADDR_W-1:0]  addr,
  output logic                   hit_c,
  output logic [DATA_W-1:0]      data_c
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    idx    = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (entries[idx].wt == addr) && (addr != ZERO_REG)) begin
        hit_c  = 1'b1;
        data_c = entries[idx].wdata;
      end
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// Write-back queue in front of the GRF write port. Buffers register writes
// from result producers in FIFO order and drains one per cycle when drain_en.
// Writes to $0 are accepted and discarded.
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_wt/in_wdata/in_pc
//        (producer side); drain_en; WE/wt/wdata/wPc (GRF write port, head
//        entry, zero when empty); count/empty/full (occupancy).
// Optional: `define GRF_WB_BYPASS_EN adds q_addr1/2 -> q_hit1/2, q_data1/2
//        combinational lookups returning the youngest queued value.
module grf_wb_queue
  import grf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_wt,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic                  drain_en,
  output logic                  WE,
  output logic [REG_ADDR_W-1:0] wt,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     wPc,
  output logic [PTR_W:0]        count,
  output logic                  empty,
  output logic                  full
`ifdef GRF_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_hit1,
  output logic                  q_hit2,
  output logic [DATA_W-1:0]     q_data1,
  output logic [DATA_W-1:0]     q_data2
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic store;
  logic pop;
  logic head_valid;

  // in_ready depends only on occupancy, so a full queue never pushes on a pop edge.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  assign push  = in_valid && in_ready;
  assign store = push && (in_wt != ZERO_REG);
  assign pop   = WE;

  // Head presentation to the GRF; forced to zero when nothing is queued.
  assign head_valid = valid_q[head_q];
  assign WE    = !empty && drain_en;
  assign wt    = head_valid ? entry_q[head_q].wt    : '0;
  assign wdata = head_valid ? entry_q[head_q].wdata : '0;
  assign wPc   = head_valid ? entry_q[head_q].pc    : '0;

  // Payload storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (store) begin
      entry_q[tail_q] <= '{wt: in_wt, wdata: in_wdata, pc: in_pc};
    end
  end

  // Pointers, occupancy and valid mask. Head/tail slots never coincide on a
  // simultaneous push and pop, since that needs the queue to be full or empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (store) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(store) - CNT_W'(pop);
    end
  end

`ifdef GRF_WB_BYPASS_EN
  wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
    .entries (entry_q),
    .valid   (valid_q),
    .head    (head_q),
    .addr    (q_addr1),
    .hit_c   (q_hit1),
    .data_c  (q_data1)
  );

  wb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
    .entries (entry_q),
    .valid   (valid_q),
    .head    (head_q),
    .addr    (q_addr2),
    .hit_c   (q_hit2),
    .data_c  (q_data2)
  );
`endif

endmodule
